uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter. It is the next generation of the team's fixed 8N1 serial sender, adding configurable data width, baud divisor, parity mode and stop-bit count, plus a proper accept/ready handshake and an end-of-frame pulse. It sits between any byte-producing logic and the board TX pin, and is driven by the system clock.

Parameters:
CLK_DIV, 5000, clock cycles per bit period; legal range 2..65535.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..64. Used only when UART_TX_FIFO_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
res  input  1  synchronous reset, active-high.
data_in  input  DATA_BITS  payload to send, LSB transmitted first.
en_data_in  input  1  write strobe; accepted only in a cycle where ready=1.
TX  output  1  serial line; idles high.
ready  output  1  1 = a write this cycle will be accepted.
busy  output  1  1 = a frame is being shifted out on TX.
done  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (res=1 at a clk edge), applied at any time including mid-frame:
  - Outputs next cycle: TX=1, busy=0, ready=1, done=0.
  - Baud counter, bit counter and shift register cleared; FIFO emptied.
  - A frame in progress is abandoned, with no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- States are IDLE, START, DATA, PAR, STOP.
  - IDLE: TX=1, busy=0. When a word is available (accepted strobe, or FIFO non-empty), load it and go to START.
  - START: TX=0 for CLK_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLK_DIV cycles.
  - PAR: entered only if PARITY!=0. One bit for CLK_DIV cycles.
    - Odd mode: XOR of the data bits, inverted.
    - Even mode: XOR of the data bits.
  - STOP: TX=1 for STOP_BITS*CLK_DIV cycles. On the last cycle, done=1 and the FSM returns to IDLE.
- Baud counter runs 0..CLK_DIV-1. A bit advances only when the counter equals CLK_DIV-1. The counter resets to 0 on every state entry.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- Latency without FIFO: strobe accepted at edge N; TX falls at edge N+1.
- busy is 1 from START entry through the last STOP cycle.
- Without FIFO: ready = (state==IDLE).
  - A strobe while ready=0 is ignored; the current frame is unaffected.
  - Minimum gap between frames is 1 idle cycle (TX=1).
- data_in is sampled only on the accepting edge. Later changes do not affect the frame in flight.
- Simultaneous res and en_data_in: res wins and the write is dropped.

Optional Feature:
Macro: UART_TX_FIFO_EN.
- Defined: a FIFO of FIFO_DEPTH words sits in front of the shifter.
  - ready = !fifo_full; a write is accepted in any state while not full.
  - A write when full is dropped; FIFO contents are unchanged.
  - The FSM pops the FIFO in IDLE, or on the last STOP cycle if the FIFO is non-empty. Frames then run back-to-back with zero idle cycles: the next START begins on the cycle after done.
  - A write and a pop in the same cycle while full: the pop takes effect, ready stays 0 that cycle, and the write is dropped.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: no FIFO logic; single-word behaviour as described in Behaviour.

Test Plan:
1. CLK_DIV=16, 8N1, write 8'h0A after reset.
   - TX sequence 0,0,1,0,1,0,0,0,0,1, each bit 16 cycles.
   - done pulses once at cycle 160 after TX falls; busy=0 afterwards.
2. CLK_DIV=4, DATA_BITS=7, PARITY=2, STOP_BITS=2, write 7'h53.
   - Parity bit = 0.
   - Frame is 11 bits = 44 cycles, with two high stop bits.
3. No FIFO; write 8'h55, then strobe 8'hFF 10 cycles later while ready=0.
   - Second write is ignored; only 8'h55 is sent.
4. Assert res for 1 cycle at the 5th data bit of a frame.
   - TX=1 and busy=0 on the next cycle; no done pulse.
   - A new write afterwards transmits normally.
5. With UART_TX_FIFO_EN, FIFO_DEPTH=4: write 5 words in consecutive cycles (8'h01..8'h05) from idle.
   - Frames run back-to-back with no idle gap; 5 done pulses.
   - ready drops when the FIFO fills and reasserts after a pop.
6. PARITY=1, CLK_DIV=8, write 8'h00 then 8'hFF.
   - Parity bits are 1 and 1 respectively.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity, 1-2 stops).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-word FIFO in front of the shifter.
module uart_tx_frame #(
    parameter int unsigned CLK_DIV    = 5000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 en_data_in,
    output logic                 TX,
    output logic                 ready,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tick;
    logic                 stop_last;
    logic                 load;
    logic [DATA_BITS-1:0] load_data;
    logic                 tx_nx, busy_nx, done_nx, ready_nx;

    assign tick      = (baud_cnt == CNT_MAX);
    assign stop_last = (state == S_STOP) && tick && (bit_cnt == STOP_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW_F = AW + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW_F-1:0]      count, count_nx;
    logic                 push, pop, full, empty;

    assign full      = (count == CW_F'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = en_data_in && !full;
    // Pop in IDLE, or on the final stop cycle so the next frame follows with no gap.
    assign pop       = !empty && ((state == S_IDLE) || stop_last);
    assign load      = pop;
    assign load_data = mem[rd_ptr];
    assign count_nx  = count + CW_F'(push) - CW_F'(pop);

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !res) mem[wr_ptr] <= data_in;
    end
`else
    assign load      = en_data_in && (state == S_IDLE);
    assign load_data = data_in;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (res) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (load) state_nx = S_START;
            S_START: if (tick) state_nx = S_DATA;
            S_DATA:  if (tick && bit_cnt == DATA_LAST) state_nx = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (tick) state_nx = S_STOP;
            S_STOP:  if (stop_last) state_nx = load ? S_START : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Baud/bit counters restart on every state entry; shifter loads on accept
    always_ff @(posedge clk) begin
        if (res) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (state_nx != state || state == S_IDLE || tick) baud_cnt <= '0;
            else                                              baud_cnt <= baud_cnt + CNT_W'(1);
            if (state_nx != state) bit_cnt <= '0;
            else if (tick)         bit_cnt <= bit_cnt + BIT_W'(1);
            if (load) begin
                shreg   <= load_data;
                par_bit <= (PARITY == 1) ? ~^load_data : ^load_data;
            end else if (state == S_DATA && tick) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // Output decode, registered below
    always_comb begin
        tx_nx   = 1'b1;
        busy_nx = 1'b1;
        done_nx = 1'b0;
        unique case (state)
            S_IDLE:  busy_nx = 1'b0;
            S_START: tx_nx   = 1'b0;
            S_DATA:  tx_nx   = shreg[0];
            S_PAR:   tx_nx   = par_bit;
            S_STOP:  done_nx = stop_last;
            default: busy_nx = 1'b0;
        endcase
`ifdef UART_TX_FIFO_EN
        ready_nx = (count_nx != CW_F'(FIFO_DEPTH));
`else
        ready_nx = (state_nx == S_IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            TX    <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            TX    <= tx_nx;
            busy  <= busy_nx;
            ready <= ready_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame over three parameter sets; per-instance monitors check every TX cycle.
// Build with +define+UART_TX_FIFO_EN to exercise the FIFO variant.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_w   [3];
    logic       en_w    [3];
    logic       tx_w    [3];
    logic       ready_w [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] data0, data2;
    logic [6:0] data1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt  [3] = '{default: 0};
    int last_done [3] = '{default: 0};
    logic [15:0] exp_q [3][$];

    // 8N1, 16 clocks per bit
    uart_tx_frame #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .res(res_w[0]), .data_in(data0), .en_data_in(en_w[0]),
        .TX(tx_w[0]), .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    // 7E2, 4 clocks per bit
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .res(res_w[1]), .data_in(data1), .en_data_in(en_w[1]),
        .TX(tx_w[1]), .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    // 8O1, 8 clocks per bit
    uart_tx_frame #(.CLK_DIV(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .res(res_w[2]), .data_in(data2), .en_data_in(en_w[2]),
        .TX(tx_w[2]), .ready(ready_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] === 1'b1) begin
                done_cnt[i]  <= done_cnt[i] + 1;
                last_done[i] <= cyc;
            end
        end
    end

    function automatic int div_of(input int id);
        case (id)
            0:       return 16;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int nb_of(input int id);
        case (id)
            0:       return 10;
            default: return 11;
        endcase
    endfunction

    // Line bits in send order; unused upper bits read as idle-high.
    function automatic logic [15:0] frame(input logic [8:0] d, input int nbits,
                                          input logic has_par, input logic par);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nbits; i++) f[1+i] = d[i];
        if (has_par) f[nbits+1] = par;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input int id, input logic [8:0] d);
        case (id)
            0:       data0 = d[7:0];
            1:       data1 = d[6:0];
            default: data2 = d[7:0];
        endcase
    endtask

    task automatic write(input int id, input logic [8:0] d);
        int t;
        t = 0;
        while (ready_w[id] !== 1'b1 && t < 1000) begin
            step(1);
            t++;
        end
        check($sformatf("write_ready inst%0d", id), 32'(ready_w[id]), 32'd1);
        set_data(id, d);
        en_w[id] = 1'b1;
        step(1);
        en_w[id] = 1'b0;
    endtask

    task automatic wait_done(input int id, input int target, input int budget);
        int t;
        t = 0;
        while (done_cnt[id] < target && t < budget) begin
            step(1);
            t++;
        end
        check($sformatf("done_count inst%0d", id), 32'(done_cnt[id]), 32'(target));
    endtask

    // Pops the expected frame at each start bit and checks every cycle of it.
    task automatic monitor(input int id);
        int div, len, bad_c;
        logic [15:0] exp, obs;
        logic have_exp, aborted, done_ok, busy_ok;
        div = div_of(id);
        len = nb_of(id) * div;
        forever begin
            @(negedge clk);
            if (res_w[id] !== 1'b0 || tx_w[id] !== 1'b0) continue;
            have_exp = (exp_q[id].size() != 0);
            exp = 16'hFFFF;
            if (have_exp) exp = exp_q[id].pop_front();
            else begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame inst%0d: start bit at cycle %0d, expected idle line", id, cyc);
            end
            aborted = 1'b0;
            bad_c   = -1;
            done_ok = 1'b1;
            busy_ok = 1'b1;
            obs     = '1;
            for (int c = 0; c < len; c++) begin
                if (c != 0) @(negedge clk);
                if (res_w[id] === 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (c % div == div / 2) obs[c / div] = tx_w[id];
                if (bad_c < 0 && tx_w[id] !== exp[c / div]) bad_c = c;
                if (done_w[id] !== 1'(c == len - 1)) done_ok = 1'b0;
                if (busy_w[id] !== 1'b1) busy_ok = 1'b0;
            end
            if (have_exp && !aborted) begin
                check($sformatf("frame_bits inst%0d", id), 32'(obs), 32'(exp));
                check($sformatf("frame_first_bad_cycle inst%0d", id), 32'(bad_c), 32'hFFFF_FFFF);
                check($sformatf("frame_done_last_cycle inst%0d", id), 32'(done_ok), 32'd1);
                check($sformatf("frame_busy inst%0d", id), 32'(busy_ok), 32'd1);
            end
        end
    endtask

    initial begin
        int base, t, t1;
        for (int i = 0; i < 3; i++) begin
            res_w[i] = 1'b1;
            en_w[i]  = 1'b0;
        end
        data0 = '0;
        data1 = '0;
        data2 = '0;
        step(3);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_state inst%0d", i),
                  {28'd0, tx_w[i], busy_w[i], ready_w[i], done_w[i]}, 32'hA);
        for (int i = 0; i < 3; i++) res_w[i] = 1'b0;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        step(2);

        // 8N1 0x0A: 0,0,1,0,1,0,0,0,0,1
        exp_q[0].push_back(16'hFE14);
        write(0, 9'h00A);
        check("latency_tx_high_after_accept", 32'(tx_w[0]), 32'd1);
        step(1);
`ifdef UART_TX_FIFO_EN
        check("latency_tx_high_fifo", 32'(tx_w[0]), 32'd1);
        step(1);
`endif
        check("latency_tx_fall", 32'(tx_w[0]), 32'd0);
        check("busy_in_frame", 32'(busy_w[0]), 32'd1);
        wait_done(0, 1, 200);
        step(5);
        check("idle_after_frame", {30'd0, busy_w[0], ready_w[0]}, 32'h1);

        // Strobe while busy
        base = done_cnt[0];
        exp_q[0].push_back(frame(9'h055, 8, 1'b0, 1'b0));
        write(0, 9'h055);
        step(9);
`ifdef UART_TX_FIFO_EN
        check("ready_while_busy_fifo", 32'(ready_w[0]), 32'd1);
        exp_q[0].push_back(frame(9'h0FF, 8, 1'b0, 1'b0));
`else
        check("ready_while_busy", 32'(ready_w[0]), 32'd0);
`endif
        set_data(0, 9'h0FF);
        en_w[0] = 1'b1;
        step(1);
        en_w[0] = 1'b0;
`ifdef UART_TX_FIFO_EN
        wait_done(0, base + 2, 500);
`else
        wait_done(0, base + 1, 300);
`endif
        step(200);
`ifdef UART_TX_FIFO_EN
        check("no_extra_frame", 32'(done_cnt[0]), 32'(base + 2));
`else
        check("no_extra_frame", 32'(done_cnt[0]), 32'(base + 1));
`endif

        // Reset during the 5th data bit
        base = done_cnt[0];
        exp_q[0].push_back(frame(9'h03C, 8, 1'b0, 1'b0));
        write(0, 9'h03C);
        step(85);
        res_w[0] = 1'b1;
        step(1);
        res_w[0] = 1'b0;
        check("midframe_reset_state", {28'd0, tx_w[0], busy_w[0], ready_w[0], done_w[0]}, 32'hA);
        step(200);
        check("no_done_after_abort", 32'(done_cnt[0]), 32'(base));
        exp_q[0].push_back(frame(9'h0C3, 8, 1'b0, 1'b0));
        write(0, 9'h0C3);
        wait_done(0, base + 1, 300);

        // 7E2: 0x53 parity 0, 0x7F parity 1
        exp_q[1].push_back(frame(9'h053, 7, 1'b1, 1'b0));
        exp_q[1].push_back(frame(9'h07F, 7, 1'b1, 1'b1));
        write(1, 9'h053);
        write(1, 9'h07F);
        wait_done(1, 2, 200);

        // 8O1: 0x00 -> 1, 0xFF -> 1, 0x80 -> 0
        exp_q[2].push_back(frame(9'h000, 8, 1'b1, 1'b1));
        exp_q[2].push_back(frame(9'h0FF, 8, 1'b1, 1'b1));
        exp_q[2].push_back(frame(9'h080, 8, 1'b1, 1'b0));
        write(2, 9'h000);
        write(2, 9'h0FF);
        wait_done(2, 1, 200);
        t1 = last_done[2];
        wait_done(2, 2, 200);
`ifdef UART_TX_FIFO_EN
        check("frame_spacing_inst2", 32'(last_done[2] - t1), 32'd88);
`else
        check("frame_spacing_inst2", 32'(last_done[2] - t1), 32'd89);
`endif
        write(2, 9'h080);
        wait_done(2, 3, 200);

        // Reset and write in the same cycle: write dropped
        base = done_cnt[2];
        set_data(2, 9'h05A);
        res_w[2] = 1'b1;
        en_w[2]  = 1'b1;
        step(1);
        res_w[2] = 1'b0;
        en_w[2]  = 1'b0;
        check("res_with_write_state", {28'd0, tx_w[2], busy_w[2], ready_w[2], done_w[2]}, 32'hA);
        step(150);
        check("res_with_write_no_frame", 32'(done_cnt[2]), 32'(base));

`ifdef UART_TX_FIFO_EN
        // Five back-to-back writes into a 4-deep FIFO
        base = done_cnt[0];
        for (int k = 1; k <= 5; k++) exp_q[0].push_back(frame(9'(k), 8, 1'b0, 1'b0));
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("fifo_ready_before_write%0d", k), 32'(ready_w[0]), 32'd1);
            set_data(0, 9'(k));
            en_w[0] = 1'b1;
            step(1);
        end
        en_w[0] = 1'b0;
        check("fifo_full_ready_low", 32'(ready_w[0]), 32'd0);
        t = 0;
        while (ready_w[0] !== 1'b1 && t < 300) begin
            step(1);
            t++;
        end
        check("fifo_ready_after_pop", 32'(ready_w[0]), 32'd1);
        wait_done(0, base + 1, 300);
        t1 = last_done[0];
        wait_done(0, base + 5, 900);
        check("fifo_back_to_back_span", 32'(last_done[0] - t1), 32'd640);
`endif

        step(20);
        for (int i = 0; i < 3; i++)
            check($sformatf("scoreboard_empty inst%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
